// File: rtl/q_measure_frontend.sv
// rtl/q_measure_frontend.sv - current-reference DAC driver with settle wait and averaged ADC amplitude measurement
//
// Purpose:
//   Latches the requested current-reference code, drives it to the DAC,
//   waits SETTLE_CYCLES, then averages 2**LOG2_AVG valid ADC samples and
//   publishes the truncated mean with a one-cycle strobe.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   i_ref_setup  in   [WIDTH] requested current-reference code
//   adc_sample   in   [WIDTH] unsigned amplitude sample
//   adc_valid    in   adc_sample qualifier
//   dac_code     out  [WIDTH] registered DAC code
//   q_measured   out  [WIDTH] last completed average, held between measurements
//   q_valid      out  one-cycle pulse while q_measured shows a fresh result
//   busy         out  high while a measurement is in flight (SETTLE/ACQUIRE/PUBLISH)
//
// Configuration:
//   Q_MEASURE_RETRIGGER_EN  when defined, a reference change during SETTLE or
//                           ACQUIRE restarts the measurement with the new code;
//                           when undefined, the change waits for IDLE.

module q_measure_frontend #(
    parameter int WIDTH         = 10,
    parameter int LOG2_AVG      = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_ref_setup,
    input  logic [WIDTH-1:0] adc_sample,
    input  logic             adc_valid,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] q_measured,
    output logic             q_valid,
    output logic             busy
);

    localparam int ACC_W = WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST =
        SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // With no settle time the DAC update goes straight into acquisition.
    localparam state_t ST_AFTER_LOAD = (SETTLE_CYCLES == 0) ? ST_ACQUIRE : ST_SETTLE;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ref_lat_q, ref_lat_d;
    logic [WIDTH-1:0]   dac_q, dac_d;
    logic [WIDTH-1:0]   q_meas_q, q_meas_d;
    logic               first_pend_q, first_pend_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic               ref_changed;
    logic               retrigger;
    logic               load;
    logic [ACC_W-1:0]   acc_sum;

    assign ref_changed = (i_ref_setup != ref_lat_q);
    assign acc_sum     = acc_q + ACC_W'(adc_sample);

`ifdef Q_MEASURE_RETRIGGER_EN
    assign retrigger = ref_changed;
`else
    assign retrigger = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ref_lat_q    <= '0;
            dac_q        <= '0;
            q_meas_q     <= '0;
            first_pend_q <= 1'b1;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            ref_lat_q    <= ref_lat_d;
            dac_q        <= dac_d;
            q_meas_q     <= q_meas_d;
            first_pend_q <= first_pend_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ref_lat_d    = ref_lat_q;
        dac_d        = dac_q;
        q_meas_d     = q_meas_q;
        first_pend_d = first_pend_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The very first measurement after reset runs even when the
                // requested code equals the reset value of ref_lat.
                if (first_pend_q || ref_changed) begin
                    load = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (retrigger) begin
                    load = 1'b1;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_ACQUIRE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end

            ST_ACQUIRE: begin
                // A restart wins over a sample arriving in the same cycle:
                // that sample belongs to the abandoned operating point.
                if (retrigger) begin
                    load = 1'b1;
                end else if (adc_valid) begin
                    acc_d        = acc_sum;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        // Result is registered here so it is already visible
                        // during the PUBLISH cycle alongside q_valid.
                        q_meas_d = acc_sum[ACC_W-1:LOG2_AVG];
                        state_d  = ST_PUBLISH;
                    end
                end
            end

            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            ref_lat_d    = i_ref_setup;
            dac_d        = i_ref_setup;
            acc_d        = '0;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            first_pend_d = 1'b0;
            state_d      = ST_AFTER_LOAD;
        end
    end

    assign dac_code   = dac_q;
    assign q_measured = q_meas_q;
    assign q_valid    = (state_q == ST_PUBLISH);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_q_measure_frontend.sv
// tb/tb_q_measure_frontend.sv - self-checking bench for q_measure_frontend with a behavioural measurement model

module tb_q_measure_frontend;

    localparam int NAVG = 4;
`ifdef Q_MEASURE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic [9:0] ref_r = '0;
    logic       vld_r = 1'b0;
    logic [9:0] smp_r = '0;

    logic [9:0] dac_a, q_a, dac_b, q_b;
    logic       qv_a, busy_a, qv_b, busy_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    q_measure_frontend u_dut_a (
        .clk        (clk),
        .rst        (rst_r),
        .i_ref_setup(ref_r),
        .adc_sample (smp_r),
        .adc_valid  (vld_r),
        .dac_code   (dac_a),
        .q_measured (q_a),
        .q_valid    (qv_a),
        .busy       (busy_a)
    );

    q_measure_frontend #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst_r),
        .i_ref_setup(ref_r),
        .adc_sample (smp_r),
        .adc_valid  (vld_r),
        .dac_code   (dac_b),
        .q_measured (q_b),
        .q_valid    (qv_b),
        .busy       (busy_b)
    );

    // Behavioural model: one measurement = trigger, then count cycles since
    // the trigger; samples count once age reaches the settle time; after the
    // Nth sample the mean is shown for exactly one cycle.
    bit m_act[2]   = '{0, 0};
    bit m_done[2]  = '{0, 0};
    bit m_first[2] = '{1, 1};
    int m_age[2]   = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_sum[2]   = '{0, 0};
    int m_ref[2]   = '{0, 0};
    int m_dac[2]   = '{0, 0};
    int m_q[2]     = '{0, 0};

    function automatic int settle_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst_r) begin
                m_act[k] = 0; m_done[k] = 0; m_first[k] = 1;
                m_ref[k] = 0; m_dac[k] = 0; m_q[k] = 0;
            end else if (m_done[k]) begin
                m_done[k] = 0;
                m_act[k]  = 0;
            end else if (m_act[k] && !(RETRIG && int'(ref_r) != m_ref[k])) begin
                if (m_age[k] >= settle_of(k) && vld_r) begin
                    m_sum[k] += int'(smp_r);
                    m_cnt[k]++;
                    if (m_cnt[k] == NAVG) begin
                        m_done[k] = 1;
                        m_q[k]    = m_sum[k] / NAVG;
                    end
                end
                m_age[k]++;
            end else if (m_first[k] || int'(ref_r) != m_ref[k]) begin
                m_first[k] = 0;
                m_ref[k]   = int'(ref_r);
                m_dac[k]   = m_ref[k];
                m_act[k]   = 1;
                m_age[k]   = 0;
                m_cnt[k]   = 0;
                m_sum[k]   = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_dac_code",   int'(dac_a),  m_dac[0]);
            chk("a_q_measured", int'(q_a),    m_q[0]);
            chk("a_q_valid",    int'(qv_a),   int'(m_done[0]));
            chk("a_busy",       int'(busy_a), int'(m_act[0]));
            chk("b_dac_code",   int'(dac_b),  m_dac[1]);
            chk("b_q_measured", int'(q_b),    m_q[1]);
            chk("b_q_valid",    int'(qv_b),   int'(m_done[1]));
            chk("b_busy",       int'(busy_b), int'(m_act[1]));
        end
    end

    // Inputs for one cycle; returns at the following falling edge so the
    // caller observes the outputs produced by this cycle's rising edge.
    task automatic drive(input logic r, input logic [9:0] rf, input logic v, input logic [9:0] s);
        rst_r = r; ref_r = rf; vld_r = v; smp_r = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Trigger in cycle 0 (unit must be idle), samples from cycle 4 every gap
    // cycles; settle-phase cycles carry valid junk that must be ignored.
    task automatic run_meas(input string nm, input logic [9:0] rf, input int gap,
                            input int s0, input int s1, input int s2, input int s3,
                            input int exp_q, output int b_cyc);
        int smp[4];
        int last;
        bit seen;
        logic v;
        logic [9:0] s;
        smp   = '{s0, s1, s2, s3};
        last  = 4 + 3 * gap;
        seen  = 0;
        b_cyc = -1;
        for (int c = 0; c < 60 && !seen; c++) begin
            v = 1'b0;
            s = 10'd777;
            if (c >= 1 && c <= 3) v = 1'b1;
            if (c >= 4 && (c - 4) % gap == 0 && (c - 4) / gap < 4) begin
                v = 1'b1;
                s = 10'(smp[(c - 4) / gap]);
            end
            drive(1'b0, rf, v, s);
            if (qv_b && b_cyc < 0) b_cyc = c + 1;
            if (c == 0) begin
                chk({nm, "_busy_rise"}, int'(busy_a), 1);
                chk({nm, "_dac_load"},  int'(dac_a),  int'(rf));
            end
            if (qv_a) begin
                seen = 1;
                chk({nm, "_latency"}, c + 1, last + 1);
                chk({nm, "_q"},       int'(q_a), exp_q);
                chk({nm, "_dac"},     int'(dac_a), int'(rf));
            end
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        drive(1'b0, rf, 1'b0, 10'd0);
        chk({nm, "_strobe_len"}, int'(qv_a), 0);
        chk({nm, "_idle"},       int'(busy_a), 0);
    endtask

    initial begin
        int b_cyc;
        int npulse;
        int p_cyc[2];
        int p_q[2];
        int p_dac[2];
        int seq4[4];
        logic [9:0] rf;
        logic v;
        logic [9:0] s;

        // Reset and first measurement
        drive(1'b1, 10'd0, 1'b0, 10'd0);
        chk_en = 1'b1;
        drive(1'b1, 10'd0, 1'b0, 10'd0);
        chk("rst_dac",   int'(dac_a),  0);
        chk("rst_q",     int'(q_a),    0);
        chk("rst_valid", int'(qv_a),   0);
        chk("rst_busy",  int'(busy_a), 0);
        run_meas("first", 10'd0, 1, 100, 102, 98, 100, 100, b_cyc);
        chk("settle0_qvalid_cycle", b_cyc, 5);

        // Truncation: full-scale then a mean that truncates to zero
        drive(1'b1, 10'd0, 1'b0, 10'd0);
        drive(1'b1, 10'd0, 1'b0, 10'd0);
        run_meas("fullscale", 10'd0, 1, 1023, 1023, 1023, 1023, 1023, b_cyc);
        run_meas("trunc",     10'd5, 1, 1, 1, 1, 0, 0, b_cyc);

        // Sparse adc_valid
        run_meas("sparse", 10'd7, 3, 40, 41, 42, 43, 41, b_cyc);

        // Reference change 5 -> 9 after two accepted samples
        seq4   = '{10, 20, 30, 40};
        npulse = 0;
        for (int c = 0; c <= 20; c++) begin
            rf = (c < 6) ? 10'd5 : 10'd9;
            v  = 1'b0;
            s  = 10'd0;
            if (c >= 4 && c <= 7) begin v = 1'b1; s = 10'(seq4[c - 4]); end
            if (c >= 8)           begin v = 1'b1; s = 10'd50; end
            drive(1'b0, rf, v, s);
            if (c + 1 == 7) begin
`ifdef Q_MEASURE_RETRIGGER_EN
                chk("chg_dac_next_edge", int'(dac_a), 9);
`else
                chk("chg_dac_held", int'(dac_a), 5);
`endif
            end
            if (qv_a) begin
                if (npulse < 2) begin
                    p_cyc[npulse] = c + 1;
                    p_q[npulse]   = int'(q_a);
                    p_dac[npulse] = int'(dac_a);
                end
                npulse++;
            end
        end
`ifdef Q_MEASURE_RETRIGGER_EN
        chk("chg_pulses", npulse, 1);
        if (npulse >= 1) begin
            chk("chg_p0_cycle", p_cyc[0], 14);
            chk("chg_p0_q",     p_q[0],   50);
            chk("chg_p0_dac",   p_dac[0], 9);
        end
`else
        chk("chg_pulses", npulse, 2);
        if (npulse >= 2) begin
            chk("chg_p0_cycle", p_cyc[0], 8);
            chk("chg_p0_q",     p_q[0],   25);
            chk("chg_p0_dac",   p_dac[0], 5);
            chk("chg_p1_cycle", p_cyc[1], 17);
            chk("chg_p1_q",     p_q[1],   50);
            chk("chg_p1_dac",   p_dac[1], 9);
        end
`endif

        // Reset in the middle of acquisition
        npulse = 0;
        for (int c = 0; c <= 6; c++) begin
            v = (c == 4 || c == 5);
            drive((c == 6), 10'd3, v, 10'd200);
            if (qv_a) npulse++;
        end
        chk("rstacq_no_pulse", npulse, 0);
        chk("rstacq_dac",      int'(dac_a),  0);
        chk("rstacq_q",        int'(q_a),    0);
        chk("rstacq_busy",     int'(busy_a), 0);
        run_meas("rst_recover", 10'd3, 1, 8, 9, 10, 11, 9, b_cyc);

        // Randomised traffic against the model
        rf = 10'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0)
                rf = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            drive(($urandom_range(0, 299) == 0), rf,
                  ($urandom_range(0, 2) != 0), 10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
